mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the multicycle RISC-V core between two requesters: the instruction-fetch path (F) and the load/store data path (D).
- Arbitrates between them round-robin and drives the memory control signals for a fixed access window.
- Returns read data and a one-cycle done pulse to the granted requester.
- Sits between the control unit's MemRead/MemWrite/IorD sequencing and the memory model; it replaces direct IorD muxing.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- MEM_LATENCY, 2, cycles the memory strobes stay asserted per access. Minimum is 1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch request; held high until f_done.
- f_addr  in  ADDR_WIDTH  fetch address; stable while f_req is high.
- f_done  out  1  one-cycle pulse: fetch complete, rdata valid.
- d_req  in  1  data request; held high until d_done.
- d_we  in  1  1 = store, 0 = load; stable while d_req is high.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_done  out  1  one-cycle pulse: data access complete.
- rdata  out  DATA_WIDTH  registered read data for the last read.
- busy  out  1  high in BUSY and DONE.
- mem_addr  out  ADDR_WIDTH  registered memory address.
- mem_wdata  out  DATA_WIDTH  registered memory write data.
- mem_read  out  1  registered read strobe.
- mem_write  out  1  registered write strobe.
- mem_rdata  in  DATA_WIDTH  memory read data; valid in the last strobe cycle.

Behaviour:
- Reset (asynchronous, reset_n low):
  - All outputs go to 0 immediately: state=IDLE, cnt=0, owner=F, last_grant=D.
  - An in-flight access is abandoned; no done pulse is issued for it.
- States: IDLE, BUSY, DONE (2-bit encoding).
- IDLE, arbitration at the rising edge:
  - Only f_req high -> grant F.
  - Only d_req high -> grant D.
  - Both high -> grant the requester that is not last_grant.
  - Neither high -> stay in IDLE.
  - On grant: latch owner; load mem_addr from the owner's address; load mem_wdata=d_wdata (D only; F leaves mem_wdata unchanged).
  - Strobes on grant: F gets mem_read=1. D gets mem_read=~d_we and mem_write=d_we.
  - Also on grant: cnt=MEM_LATENCY-1, next state BUSY.
- BUSY:
  - Strobes stay asserted for exactly MEM_LATENCY cycles.
  - cnt>0: decrement.
  - cnt==0 at the edge:
    - If the access was a read, rdata<=mem_rdata; for a write, rdata is held.
    - Clear mem_read and mem_write; mem_addr and mem_wdata hold.
    - Set the owner's done=1; last_grant<=owner; next state DONE.
- DONE:
  - Exactly one cycle with the owner's done high.
  - At the edge: done<=0, next state IDLE.
  - f_done and d_done are never both high.
- Timing:
  - Total per access, from the edge after req is seen in IDLE to done high: MEM_LATENCY+1 edges.
  - Back-to-back turnaround costs 1 IDLE cycle.
- Request rule: the requester drops req at the edge ending the done cycle. If req is still high in IDLE, it is a new request.
- No effect during BUSY/DONE: requests and input changes are ignored, including the address inputs.
- Fetch path never writes.

Test Plan:
- Reset: hold reset_n=0 with f_req=d_req=1 -> all outputs 0, no strobes. Release -> F granted first (last_grant=D).
- Single fetch, MEM_LATENCY=2, f_addr=0x40, mem_rdata=0x00500093:
  - mem_read=1 with mem_addr=0x40 for exactly 2 cycles.
  - f_done pulses 1 cycle after strobes drop; rdata=0x00500093.
- Store: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF:
  - mem_write=1 for 2 cycles with that address and data; mem_read=0.
  - d_done pulses once; rdata unchanged.
- Contention: f_req and d_req asserted same cycle, both held continuously:
  - Grants alternate F, D, F, D.
  - Each done is 1 cycle; never both dones high.
- Reset mid-BUSY: assert reset_n=0 during the first strobe cycle of a load -> strobes drop asynchronously, no d_done. After release with d_req still high -> clean fresh access.
- MEM_LATENCY=1 and MEM_LATENCY=4 -> strobe width is 1 and 4 respectively; done latency is 2 and 5 edges.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one memory port between instruction fetch (F) and load/store (D).
// Each grant holds the memory strobes for MEM_LATENCY cycles, then pulses the owner's done for one cycle.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_done,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic OWN_F = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    owner_q, owner_d;
    logic                    last_q, last_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;
    logic                    fdone_q, fdone_d;
    logic                    ddone_q, ddone_d;

    logic req_any;
    logic pick_d;

    // On contention the requester that did not win last time gets the port.
    assign req_any = f_req | d_req;
    assign pick_d  = d_req & (~f_req | (last_q == OWN_F));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= OWN_F;
            last_q  <= OWN_D;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            fdone_q <= 1'b0;
            ddone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            fdone_q <= fdone_d;
            ddone_q <= ddone_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_any) state_d = BUSY;
            BUSY:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        fdone_d = fdone_q;
        ddone_d = ddone_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    owner_d = pick_d;
                    cnt_d   = CNT_LOAD;
                    if (pick_d) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        rd_d    = ~d_we;
                        wr_d    = d_we;
                    end else begin
                        addr_d = f_addr;
                        rd_d   = 1'b1;
                        wr_d   = 1'b0;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // mem_rdata is valid in the last strobe cycle; writes keep the old rdata.
                    if (rd_q) rdata_d = mem_rdata;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    fdone_d = (owner_q == OWN_F);
                    ddone_d = (owner_q == OWN_D);
                    last_d  = owner_q;
                end
            end
            DONE: begin
                fdone_d = 1'b0;
                ddone_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign f_done    = fdone_q;
    assign d_done    = ddone_q;
    assign rdata     = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_read  = rd_q;
    assign mem_write = wr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LATENCY 2, 1, 4) checked every cycle against a
// time-since-grant reference model, plus directed reset, contention and reset-during-access scenarios.
module tb_mem_port_arbiter;

    localparam int NL = 3;

    function automatic int lat(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 4;
    endfunction

    logic        clk = 1'b0;
    logic        reset_n;
    logic        f_req     [NL];
    logic        d_req     [NL];
    logic        d_we      [NL];
    logic [31:0] f_addr    [NL];
    logic [31:0] d_addr    [NL];
    logic [31:0] d_wdata   [NL];
    logic [31:0] mem_rdata [NL];
    logic        f_done    [NL];
    logic        d_done    [NL];
    logic        busy      [NL];
    logic        mem_read  [NL];
    logic        mem_write [NL];
    logic [31:0] rdata     [NL];
    logic [31:0] mem_addr  [NL];
    logic [31:0] mem_wdata [NL];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .MEM_LATENCY((g == 0) ? 2 : (g == 1) ? 1 : 4)
        ) u_dut (
            .clk      (clk),
            .reset_n  (reset_n),
            .f_req    (f_req[g]),
            .f_addr   (f_addr[g]),
            .f_done   (f_done[g]),
            .d_req    (d_req[g]),
            .d_we     (d_we[g]),
            .d_addr   (d_addr[g]),
            .d_wdata  (d_wdata[g]),
            .d_done   (d_done[g]),
            .rdata    (rdata[g]),
            .busy     (busy[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_read (mem_read[g]),
            .mem_write(mem_write[g]),
            .mem_rdata(mem_rdata[g])
        );
    end

    // Reference model: an access is described only by the edge it was granted on.
    bit          m_active [NL];
    int          m_g      [NL];
    bit          m_owner  [NL];
    bit          m_last   [NL];
    bit          m_isrd   [NL];
    logic [31:0] m_addr   [NL];
    logic [31:0] m_wdata  [NL];
    logic [31:0] m_rdata  [NL];

    int   edge_n = 0;
    int   tests  = 0;
    int   fails  = 0;
    bit   hold   = 1'b0;
    bit   obs_on = 1'b0;
    bit   prev_s [NL];
    int   run    [NL];
    int   first_w[NL];
    int   first_done_edge[NL];
    int   rel_edge = 0;
    int   gseq_n = 0;
    logic [3:0] gseq = 4'b0;
    bit   first_wr_seen = 1'b0;
    int   dd_cnt = 0;

    function automatic int age(input int k);
        return edge_n - m_g[k];
    endfunction

    function automatic bit any_active();
        bit r = 1'b0;
        for (int k = 0; k < NL; k++) r |= m_active[k];
        return r;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s lane%0d: got %h expected %h", nm, k, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NL; k++) begin
            m_active[k] = 1'b0;
            m_g[k]      = 0;
            m_owner[k]  = 1'b0;
            m_last[k]   = 1'b1;
            m_isrd[k]   = 1'b0;
            m_addr[k]   = '0;
            m_wdata[k]  = '0;
            m_rdata[k]  = '0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < NL; k++) begin
            if (m_active[k]) begin
                if (age(k) == lat(k)) begin
                    if (m_isrd[k]) m_rdata[k] = mem_rdata[k];
                    m_last[k] = m_owner[k];
                end else if (age(k) == lat(k) + 1) begin
                    m_active[k] = 1'b0;
                end
            end else if (f_req[k] || d_req[k]) begin
                bit pd;
                pd = d_req[k] && (!f_req[k] || !m_last[k]);
                m_active[k] = 1'b1;
                m_g[k]      = edge_n;
                m_owner[k]  = pd;
                if (pd) begin
                    m_addr[k]  = d_addr[k];
                    m_wdata[k] = d_wdata[k];
                    m_isrd[k]  = !d_we[k];
                end else begin
                    m_addr[k] = f_addr[k];
                    m_isrd[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic compare();
        for (int k = 0; k < NL; k++) begin
            bit strobe, fin;
            strobe = m_active[k] && (age(k) < lat(k));
            fin    = m_active[k] && (age(k) == lat(k));
            chk("mem_read",  k, mem_read[k],  strobe && m_isrd[k]);
            chk("mem_write", k, mem_write[k], strobe && !m_isrd[k]);
            chk("f_done",    k, f_done[k],    fin && !m_owner[k]);
            chk("d_done",    k, d_done[k],    fin && m_owner[k]);
            chk("busy",      k, busy[k],      m_active[k]);
            chk("mem_addr",  k, mem_addr[k],  m_addr[k]);
            chk("mem_wdata", k, mem_wdata[k], m_wdata[k]);
            chk("rdata",     k, rdata[k],     m_rdata[k]);
        end
    endtask

    task automatic observe();
        for (int k = 0; k < NL; k++) begin
            bit s;
            s = mem_read[k] | mem_write[k];
            if (obs_on) begin
                if (s) run[k]++;
                else if (prev_s[k]) begin
                    if (first_w[k] < 0) first_w[k] = run[k];
                    run[k] = 0;
                end
                if (f_done[k] && first_done_edge[k] < 0) first_done_edge[k] = edge_n - rel_edge;
                if (k == 0 && s && !prev_s[k]) begin
                    if (gseq_n < 4) begin
                        gseq[gseq_n] = mem_write[0];
                        gseq_n++;
                    end
                    if (mem_write[0] && !first_wr_seen) begin
                        first_wr_seen = 1'b1;
                        chk("store_addr",  0, mem_addr[0],  32'h0000_0100);
                        chk("store_wdata", 0, mem_wdata[0], 32'hDEAD_BEEF);
                        chk("store_noread", 0, mem_read[0], 1'b0);
                    end
                end
            end
            if (k == 0 && d_done[0]) dd_cnt++;
            prev_s[k] = s;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        if (reset_n) model_step();
        else model_reset();
        #1;
        compare();
        observe();
        if (!hold) begin
            for (int k = 0; k < NL; k++) begin
                if (m_active[k] && age(k) == lat(k)) begin
                    if (m_owner[k]) d_req[k] = 1'b0;
                    else f_req[k] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        model_reset();
        for (int k = 0; k < NL; k++) begin
            f_req[k]     = 1'b1;
            d_req[k]     = 1'b1;
            f_addr[k]    = 32'h0000_0040;
            d_we[k]      = 1'b1;
            d_addr[k]    = 32'h0000_0100;
            d_wdata[k]   = 32'hDEAD_BEEF;
            mem_rdata[k] = 32'h0050_0093;
            prev_s[k]    = 1'b0;
            run[k]       = 0;
            first_w[k]   = -1;
            first_done_edge[k] = -1;
        end
        hold = 1'b1;

        // Reset held with both requests pending.
        repeat (3) tick();
        chk("rst_busy",  0, busy[0],     1'b0);
        chk("rst_read",  0, mem_read[0], 1'b0);
        chk("rst_write", 2, mem_write[2], 1'b0);
        chk("rst_addr",  0, mem_addr[0], 32'h0);
        chk("rst_rdata", 1, rdata[1],    32'h0);

        // Contention with both requests held continuously.
        reset_n  = 1'b1;
        rel_edge = edge_n;
        obs_on   = 1'b1;
        tick();
        chk("grantF_read", 0, mem_read[0], 1'b1);
        chk("grantF_addr", 0, mem_addr[0], 32'h0000_0040);
        repeat (20) tick();
        obs_on = 1'b0;
        chk("grant_order", 0, {28'h0, gseq}, 32'b1010);
        chk("strobe_w",  0, first_w[0], 2);
        chk("strobe_w",  1, first_w[1], 1);
        chk("strobe_w",  2, first_w[2], 4);
        chk("done_lat",  0, first_done_edge[0], 3);
        chk("done_lat",  1, first_done_edge[1], 2);
        chk("done_lat",  2, first_done_edge[2], 5);
        chk("fetch_rdata", 0, rdata[0], 32'h0050_0093);
        chk("store_seen",  0, first_wr_seen, 1'b1);

        // Drain, then abandon a load with an asynchronous reset in its first strobe cycle.
        hold = 1'b0;
        for (int k = 0; k < NL; k++) begin
            f_req[k] = 1'b0;
            d_req[k] = 1'b0;
        end
        for (int i = 0; i < 30 && any_active(); i++) tick();
        tick();
        for (int k = 0; k < NL; k++) chk("drain_busy", k, busy[k], 1'b0);
        for (int k = 0; k < NL; k++) begin
            d_req[k]     = 1'b1;
            d_we[k]      = 1'b0;
            d_addr[k]    = 32'h0000_0200;
            mem_rdata[k] = 32'h1234_5678;
        end
        tick();
        chk("load_read", 0, mem_read[0], 1'b1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_read", 0, mem_read[0], 1'b0);
        chk("arst_busy", 0, busy[0],     1'b0);
        chk("arst_addr", 0, mem_addr[0], 32'h0);
        compare();
        dd_cnt = 0;
        repeat (2) tick();
        chk("arst_nodone", 0, dd_cnt, 0);
        reset_n = 1'b1;
        repeat (8) tick();
        chk("fresh_done",  0, dd_cnt,   1);
        chk("fresh_rdata", 0, rdata[0], 32'h1234_5678);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            tick();
            for (int k = 0; k < NL; k++) begin
                if (!f_req[k]) begin
                    f_addr[k] = $urandom;
                    if ($urandom_range(3) == 0) f_req[k] = 1'b1;
                end
                if (!d_req[k]) begin
                    d_we[k]    = $urandom_range(1) == 1;
                    d_addr[k]  = $urandom;
                    d_wdata[k] = $urandom;
                    if ($urandom_range(3) == 0) d_req[k] = 1'b1;
                end
                mem_rdata[k] = $urandom;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
